alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage of the single-cycle MIPS datapath. It combines three functions: ALU operation decode (ALUop plus funct), a 32-bit ALU with zero flag and shift support, and the branch-target adder.
- Results are captured in one output register stage, so the datapath reads them one cycle after the operands are presented.
- It sits between the register file/sign-extender and the data memory and next-PC muxes.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands are valid this cycle
- ALUop  in  2  from control unit: 00 add, 01 sub, 10 R-type (use func), 11 and (andi)
- func  in  6  instruction funct field
- shmt  in  5  shift amount
- read_data1  in  32  operand A (rs)
- alu_b  in  32  operand B (rt or sign-extended immediate, already muxed)
- address_plus4  in  32  PC+4
- imm_32  in  32  sign-extended immediate
- out_valid  out  1  registered in_valid
- ALU_out  out  32  registered ALU result
- ZERO  out  1  registered (ALU result == 0)
- adder2_result  out  32  registered branch target
- Jr  out  1  registered jump-register flag
- ALU_operation  out  4  registered decoded operation code

Behaviour:
- Reset: while reset_n is 0, all outputs are 0 immediately (asynchronous) and held there. The first capture happens on the first rising clock edge after reset_n rises.
- Latency: exactly 1 cycle. On every rising edge all outputs load the combinational results for the current inputs.
  - Capture does not depend on in_valid; out_valid simply copies in_valid.
- Operation decode (combinational):
  - ALUop 00 -> 0010 (add)
  - ALUop 01 -> 0110 (sub)
  - ALUop 11 -> 0000 (and)
  - ALUop 10, by func:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 100111 -> 1100 (nor)
    - 101010 -> 0111 (slt)
    - 000000 -> 0011 (sll)
    - 001000 -> 1111 (jr, no-op)
    - any other func -> 1111
- Jr is 1 only when ALUop = 10 and func = 001000; otherwise 0.
- ALU (combinational), A = read_data1, B = alu_b:
  - 0000: A & B
  - 0001: A | B
  - 0010: A + B
  - 0110: A - B
  - 0111: 1 if signed A < signed B, else 0
  - 1100: ~(A | B)
  - 0011: B << shmt (logical, zero fill; shmt 0 passes B unchanged)
  - 1111 and every other code: 0
- Arithmetic wraps modulo 2^32. There is no overflow detection or trap.
- ZERO = 1 exactly when the 32-bit result is 0. This includes the 1111 code, so a jr instruction reports ZERO = 1 (harmless because Branch = 0 for jr).
- Branch target: address_plus4 + (imm_32 << 2), wrap modulo 2^32. It is computed for every instruction, regardless of ALUop.
- Reset asserted mid-operation clears the register stage at once; in-flight results are discarded.
- No internal state other than the output register.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 4-bit operation codes (OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB, OP_SLT, OP_NOR, OP_NOP)
  - ALUop encodings
  - funct constants (F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_JR)
- One natural sub-module: alu_op_decode (pure combinational ALUop/func to operation code and Jr). The ALU datapath, branch adder and output register stay in the top.

Test Plan:
- Reset: hold reset_n = 0 with nonzero inputs, toggle clock -> all outputs 0. Release, apply ALUop = 00, A = 5, B = 7 -> after one edge ALU_out = 12, ZERO = 0, ALU_operation = 0010.
- R-type sweep, A = 0xF0F0F0F0, B = 0x0FF00FF0:
  - and -> 0x00F000F0
  - or -> 0xFFF0FFF0
  - nor -> 0x000F000F
  - add -> 0x00E100E0
  - sub -> 0xE100E100
- slt signed: A = 0xFFFFFFFF, B = 1 -> ALU_out = 1. Swap operands -> 0, ZERO = 1.
- Shift: func = 000000, B = 0x00000001, shmt = 31 -> 0x80000000. shmt = 0, B = 0x1234 -> 0x1234.
- beq and branch target: ALUop = 01, A = B = 0x55 -> ZERO = 1. address_plus4 = 0x00400004, imm_32 = 0xFFFFFFFF -> adder2_result = 0x00400000. Add wrap: 0xFFFFFFFF + 1 -> ALU_out = 0, ZERO = 1.
- jr and unknown funct:
  - ALUop = 10, func = 001000 -> Jr = 1, ALU_operation = 1111, ALU_out = 0.
  - ALUop = 00, func = 001000 -> Jr = 0.
  - func = 111111 with ALUop = 10 -> ALU_out = 0.
  - Assert reset_n mid-stream -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation codes, ALUop
// values from the control unit, and R-type funct field values.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_AND    = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle of the execute stage. in_valid is a plain qualifier
// with no ready: the stage accepts every cycle and out_valid is in_valid delayed one clock.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [1:0]       ALUop;
  logic [5:0]       func;
  logic [4:0]       shmt;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] address_plus4;
  logic [WIDTH-1:0] imm_32;

  logic             out_valid;
  logic [WIDTH-1:0] ALU_out;
  logic             ZERO;
  logic [WIDTH-1:0] adder2_result;
  logic             Jr;
  logic [3:0]       ALU_operation;

  modport master (
    output in_valid, ALUop, func, shmt, read_data1, alu_b, address_plus4, imm_32,
    input  out_valid, ALU_out, ZERO, adder2_result, Jr, ALU_operation
  );

  modport slave (
    input  in_valid, ALUop, func, shmt, read_data1, alu_b, address_plus4, imm_32,
    output out_valid, ALU_out, ZERO, adder2_result, Jr, ALU_operation
  );
endinterface

// File: rtl/alu_op_decode.sv
// ALU control: maps the control unit's ALUop plus the funct field to a
// 4-bit operation code, and flags jr.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] func,
  output logic [3:0] op_code,
  output logic       jr
);

  always_comb begin
    op_code = OP_NOP;
    jr      = 1'b0;
    case (alu_op)
      ALUOP_ADD: op_code = OP_ADD;
      ALUOP_SUB: op_code = OP_SUB;
      ALUOP_AND: op_code = OP_AND;
      ALUOP_RTYPE: begin
        case (func)
          F_ADD:   op_code = OP_ADD;
          F_SUB:   op_code = OP_SUB;
          F_AND:   op_code = OP_AND;
          F_OR:    op_code = OP_OR;
          F_NOR:   op_code = OP_NOR;
          F_SLT:   op_code = OP_SLT;
          F_SLL:   op_code = OP_SLL;
          // jr does no ALU work; the unknown-funct fallback already gives OP_NOP
          F_JR: begin
            op_code = OP_NOP;
            jr      = 1'b1;
          end
          default: op_code = OP_NOP;
        endcase
      end
      default: op_code = OP_NOP;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: operation decode, 32-bit ALU with zero flag and shift,
// branch-target adder, all captured in a single output register stage.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset_n,
  alu_exec_unit_if.slave bus
);

  logic [3:0]       op_code;
  logic             jr;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] branch_target;

  alu_op_decode u_decode (
    .alu_op  (bus.ALUop),
    .func    (bus.func),
    .op_code (op_code),
    .jr      (jr)
  );

  always_comb begin
    alu_result = '0;
    case (op_code)
      OP_AND: alu_result = bus.read_data1 & bus.alu_b;
      OP_OR:  alu_result = bus.read_data1 | bus.alu_b;
      OP_ADD: alu_result = bus.read_data1 + bus.alu_b;
      OP_SUB: alu_result = bus.read_data1 - bus.alu_b;
      OP_SLT: alu_result = ($signed(bus.read_data1) < $signed(bus.alu_b)) ? WIDTH'(1) : '0;
      OP_NOR: alu_result = ~(bus.read_data1 | bus.alu_b);
      OP_SLL: alu_result = bus.alu_b << bus.shmt;
      default: alu_result = '0;
    endcase
  end

  // Branch target is produced for every instruction; the next-PC mux decides use.
  assign branch_target = bus.address_plus4 + (bus.imm_32 << 2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid     <= 1'b0;
      bus.ALU_out       <= '0;
      bus.ZERO          <= 1'b0;
      bus.adder2_result <= '0;
      bus.Jr            <= 1'b0;
      bus.ALU_operation <= 4'b0000;
    end else begin
      bus.out_valid     <= bus.in_valid;
      bus.ALU_out       <= alu_result;
      bus.ZERO          <= (alu_result == '0);
      bus.adder2_result <= branch_target;
      bus.Jr            <= jr;
      bus.ALU_operation <= op_code;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random stimulus for the execute stage, checked against an
// instruction-level model of the MIPS execute semantics.
module tb_alu_exec_unit;

  logic clock;
  logic reset_n;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res, exp_tgt;
  logic [3:0]  exp_op;
  logic        exp_jr, exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the instruction by mnemonic, then compute its result.
  task automatic model(input logic [1:0] aluop, input logic [5:0] func, input logic [4:0] shmt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc4, input logic [31:0] imm);
    string mn;
    longint sa, sb;
    if (aluop == 2'd0) mn = "add";
    else if (aluop == 2'd1) mn = "sub";
    else if (aluop == 2'd3) mn = "and";
    else begin
      case (func)
        6'd32:   mn = "add";
        6'd34:   mn = "sub";
        6'd36:   mn = "and";
        6'd37:   mn = "or";
        6'd39:   mn = "nor";
        6'd42:   mn = "slt";
        6'd0:    mn = "sll";
        default: mn = "nop";
      endcase
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_jr = (aluop == 2'd2) && (func == 6'd8);
    case (mn)
      "add": begin exp_res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); exp_op = 4'd2;  end
      "sub": begin exp_res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000); exp_op = 4'd6; end
      "and": begin exp_res = a & b;                   exp_op = 4'd0;  end
      "or":  begin exp_res = a | b;                   exp_op = 4'd1;  end
      "nor": begin exp_res = ~(a | b);                exp_op = 4'd12; end
      "slt": begin exp_res = (sa < sb) ? 32'd1 : 32'd0; exp_op = 4'd7; end
      "sll": begin exp_res = 32'((64'(b) * (64'd1 << shmt)) % 64'h1_0000_0000); exp_op = 4'd3; end
      default: begin exp_res = 32'd0;                 exp_op = 4'd15; end
    endcase
    exp_tgt = 32'((64'(pc4) + 64'(imm) * 64'd4) % 64'h1_0000_0000);
  endtask

  task automatic step(input string tag, input logic [1:0] aluop, input logic [5:0] func,
                      input logic [4:0] shmt, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc4, input logic [31:0] imm, input logic valid);
    bus.in_valid      = valid;
    bus.ALUop         = aluop;
    bus.func          = func;
    bus.shmt          = shmt;
    bus.read_data1    = a;
    bus.alu_b         = b;
    bus.address_plus4 = pc4;
    bus.imm_32        = imm;
    model(aluop, func, shmt, a, b, pc4, imm);
    exp_valid = valid;
    @(posedge clock);
    #1;
    chk({tag, ".alu_out"}, bus.ALU_out, exp_res);
    chk({tag, ".zero"},    {31'd0, bus.ZERO}, {31'd0, exp_res == 32'd0});
    chk({tag, ".op"},      {28'd0, bus.ALU_operation}, {28'd0, exp_op});
    chk({tag, ".jr"},      {31'd0, bus.Jr}, {31'd0, exp_jr});
    chk({tag, ".target"},  bus.adder2_result, exp_tgt);
    chk({tag, ".valid"},   {31'd0, bus.out_valid}, {31'd0, exp_valid});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu_out"}, bus.ALU_out, 32'd0);
    chk({tag, ".zero"},    {31'd0, bus.ZERO}, 32'd0);
    chk({tag, ".op"},      {28'd0, bus.ALU_operation}, 32'd0);
    chk({tag, ".jr"},      {31'd0, bus.Jr}, 32'd0);
    chk({tag, ".target"},  bus.adder2_result, 32'd0);
    chk({tag, ".valid"},   {31'd0, bus.out_valid}, 32'd0);
  endtask

  logic [5:0] func_pool [10];

  initial begin
    func_pool = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd8, 6'd63, 6'd3};

    // Reset with nonzero inputs present
    reset_n           = 1'b0;
    bus.in_valid      = 1'b1;
    bus.ALUop         = 2'b00;
    bus.func          = 6'd8;
    bus.shmt          = 5'd3;
    bus.read_data1    = 32'h1234_5678;
    bus.alu_b         = 32'h0000_0001;
    bus.address_plus4 = 32'h0040_0000;
    bus.imm_32        = 32'h0000_0010;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    #2;
    reset_n = 1'b1;

    step("add5_7", 2'b00, 6'd0, 5'd0, 32'd5, 32'd7, 32'd4, 32'd0, 1'b1);
    chk("add5_7.literal", bus.ALU_out, 32'd12);

    step("r_and", 2'b10, 6'b100100, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'd1, 1'b1);
    chk("r_and.literal", bus.ALU_out, 32'h00F000F0);
    step("r_or",  2'b10, 6'b100101, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'd2, 1'b0);
    chk("r_or.literal", bus.ALU_out, 32'hFFF0FFF0);
    step("r_nor", 2'b10, 6'b100111, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'd3, 1'b1);
    chk("r_nor.literal", bus.ALU_out, 32'h000F000F);
    step("r_add", 2'b10, 6'b100000, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'd4, 1'b1);
    chk("r_add.literal", bus.ALU_out, 32'h00E100E0);
    step("r_sub", 2'b10, 6'b100010, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'd5, 1'b1);
    chk("r_sub.literal", bus.ALU_out, 32'hE100E100);

    step("slt_neg", 2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1);
    chk("slt_neg.literal", bus.ALU_out, 32'd1);
    step("slt_pos", 2'b10, 6'b101010, 5'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
    chk("slt_pos.zero", {31'd0, bus.ZERO}, 32'd1);

    step("sll31", 2'b10, 6'b000000, 5'd31, 32'hDEAD, 32'h1, 32'd0, 32'd0, 1'b1);
    chk("sll31.literal", bus.ALU_out, 32'h80000000);
    step("sll0", 2'b10, 6'b000000, 5'd0, 32'hDEAD, 32'h1234, 32'd0, 32'd0, 1'b1);
    chk("sll0.literal", bus.ALU_out, 32'h1234);

    step("beq", 2'b01, 6'd0, 5'd0, 32'h55, 32'h55, 32'h00400004, 32'hFFFFFFFF, 1'b1);
    chk("beq.target_literal", bus.adder2_result, 32'h00400000);
    step("add_wrap", 2'b00, 6'd0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC, 32'h1, 1'b1);
    chk("add_wrap.zero", {31'd0, bus.ZERO}, 32'd1);

    step("jr", 2'b10, 6'b001000, 5'd0, 32'h40, 32'h40, 32'd8, 32'd0, 1'b1);
    chk("jr.flag", {31'd0, bus.Jr}, 32'd1);
    step("jr_aluop0", 2'b00, 6'b001000, 5'd0, 32'h40, 32'h40, 32'd8, 32'd0, 1'b1);
    step("bad_func", 2'b10, 6'b111111, 5'd0, 32'h40, 32'h40, 32'd8, 32'd0, 1'b1);
    step("andi", 2'b11, 6'b100101, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'd8, 32'd0, 1'b1);

    // Asynchronous reset well away from a clock edge
    step("pre_rst", 2'b00, 6'd0, 5'd0, 32'd9, 32'd9, 32'd8, 32'd1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clock);
    #1;
    chk_zero("rst_held");
    #2;
    reset_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [5:0] f;
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : func_pool[$urandom_range(0, 9)];
      step($sformatf("rnd%0d", i), op, f, 5'($urandom), $urandom, $urandom,
           $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
